// File: rtl/riscv_pkg.sv
// Shared definitions for the IMEM boot loader: loader FSM encoding and stream framing constants.
package riscv_pkg;

  localparam int HDR_BYTES   = 2;
  localparam int WORD_BYTES  = 4;
  localparam int IMEM_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles four accepted stream bytes (LSB first) into a 32-bit word; word_valid marks the 4th byte.
module boot_word_packer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  // The 4th byte is combined directly so the top can register the word on the same edge.
  assign word_valid = byte_en && (byte_cnt == 2'(WORD_BYTES - 1));
  assign word       = {byte_in, low_bytes};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from before the edge.
    if (rst || clear) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
    end else if (byte_en) begin
      byte_cnt  <= byte_cnt + 2'd1;
      low_bytes <= {byte_in, low_bytes[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Serial IMEM program loader holding the core in reset until the image is written.
// Optional checksum trailer byte enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MAX_WORDS = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       MAX_W17   = 17'(MAX_WORDS);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e       AFTER_LOAD = S_CHK;
`else
  localparam boot_state_e       AFTER_LOAD = S_DONE;
`endif

  boot_state_e       state, state_next;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       word_idx;
  logic [ADDR_W-1:0] addr_ofs;
  logic              xfer;
  logic              word_valid;
  logic [31:0]       word;
  logic              last_word;
  logic [15:0]       hdr_n;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // boot_start masks in_ready so a same-cycle byte stays with the source instead of being dropped.
  assign in_ready  = !rst && !boot_start &&
                     (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK});
  assign xfer      = in_valid && in_ready;
  assign hdr_n     = {in_data, len_lo};
  assign last_word = word_valid && (word_idx == len - 16'd1);

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (boot_start),
    .byte_en    (xfer && (state == S_DATA)),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst || boot_start) state <= S_LEN_LO;
    else                   state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_next = state;
    case (state)
      S_LEN_LO: if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (hdr_n == 16'd0)                state_next = AFTER_LOAD;
          else if ({1'b0, hdr_n} > MAX_W17)  state_next = S_ERR;
          else                               state_next = S_DATA;
        end
      end
      S_DATA: if (last_word) state_next = AFTER_LOAD;
`ifdef BOOT_CHECKSUM_EN
      S_CHK: if (xfer) state_next = (in_data == csum) ? S_DONE : S_ERR;
`endif
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_A;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      addr_ofs   <= '0;
    end else if (boot_start) begin
      imem_we   <= 1'b0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      word_idx  <= '0;
      addr_ofs  <= '0;
    end else begin
      imem_we   <= word_valid;
      cpu_rst   <= (state != S_DONE);
      load_done <= (state == S_DONE);
      load_err  <= (state == S_ERR);
      if (xfer && state == S_LEN_LO) len_lo <= in_data;
      if (xfer && state == S_LEN_HI) len    <= hdr_n;
      if (word_valid) begin
        imem_wdata <= word;
        imem_addr  <= BASE_A + addr_ofs;
        addr_ofs   <= addr_ofs + 1'b1;
        word_idx   <= word_idx + 16'd1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running XOR of every stream byte ahead of the trailer, header included.
  always_ff @(posedge clk) begin
    if (rst || boot_start)            csum <= '0;
    else if (xfer && state != S_CHK)  csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader; checksum scenarios follow BOOT_CHECKSUM_EN.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  tb_csum;
  logic [31:0] prog [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};

  imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .boot_start (boot_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready=%0b for 50 cycles, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tb_csum  = tb_csum ^ b;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic pulse_boot_start();
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    tb_csum = 8'h00;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %0b, required 0", in_ready); end
    if (imem_we !== 1'b0)    begin errors++; $display("FAIL reset_imem_we: got %0b, required 0", imem_we); end
    if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_imem_addr: got %0h, required 0", imem_addr); end
    if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_imem_wdata: got %0h, required 0", imem_wdata); end
    if (cpu_rst !== 1'b1)    begin errors++; $display("FAIL reset_cpu_rst: got %0b, required 1", cpu_rst); end
    if (load_done !== 1'b0)  begin errors++; $display("FAIL reset_load_done: got %0b, required 0", load_done); end
    if (load_err !== 1'b0)   begin errors++; $display("FAIL reset_load_err: got %0b, required 0", load_err); end
    rst = 1'b0;
    tb_csum = 8'h00;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b, required 1", in_ready); end
  endtask

  task automatic test_basic_load();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 0);
    checks += 4;
    if (imem_we !== 1'b1)          begin errors++; $display("FAIL basic_last_we: got %0b, required 1", imem_we); end
    if (imem_addr !== 8'd2)        begin errors++; $display("FAIL basic_last_addr: got %0h, required 2", imem_addr); end
    if (imem_wdata !== prog[2])    begin errors++; $display("FAIL basic_last_data: got %h, required %h", imem_wdata, prog[2]); end
    if (cpu_rst !== 1'b1)          begin errors++; $display("FAIL basic_cpu_rst_during_we: got %0b, required 1", cpu_rst); end
`ifdef BOOT_CHECKSUM_EN
    send_byte(tb_csum, 0);
`endif
    @(posedge clk);
    #1;
    checks += 5;
    if (cpu_rst !== 1'b0)   begin errors++; $display("FAIL basic_cpu_rst_release: got %0b, required 0", cpu_rst); end
    if (load_done !== 1'b1) begin errors++; $display("FAIL basic_load_done: got %0b, required 1", load_done); end
    if (load_err !== 1'b0)  begin errors++; $display("FAIL basic_load_err: got %0b, required 0", load_err); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL basic_done_in_ready: got %0b, required 0", in_ready); end
    if (wr_addr.size() != 3) begin errors++; $display("FAIL basic_write_count: got %0d, required 3", wr_addr.size()); end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== prog[i]) begin
        errors++;
        $display("FAIL basic_write_%0d: got addr %0h data %h, required addr %0h data %h",
                 i, wr_addr[i], wr_data[i], i, prog[i]);
      end
    end
  endtask

  task automatic test_gaps();
    int gaps [14] = '{3, 1, 0, 5, 2, 4, 0, 1, 5, 3, 2, 0, 4, 1};
    int ready_drops = 0;
    send_byte(8'h03, gaps[0]);
    send_byte(8'h00, gaps[1]);
    for (int i = 0; i < 12; i++) begin
      repeat (gaps[(i + 2) % 14]) begin
        @(negedge clk);
        if (!in_ready && !(i == 0)) ready_drops++;
      end
      send_byte(prog[i / 4][8*(i % 4) +: 8], 0);
      if (i < 11) begin
        @(negedge clk);
        if (!in_ready) ready_drops++;
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(tb_csum, 2);
`endif
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (ready_drops != 0)    begin errors++; $display("FAIL gaps_in_ready_drops: got %0d, required 0", ready_drops); end
    if (cpu_rst !== 1'b0)    begin errors++; $display("FAIL gaps_cpu_rst: got %0b, required 0", cpu_rst); end
    if (load_done !== 1'b1)  begin errors++; $display("FAIL gaps_load_done: got %0b, required 1", load_done); end
    if (wr_addr.size() != 3) begin errors++; $display("FAIL gaps_write_count: got %0d, required 3", wr_addr.size()); end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== prog[i]) begin
        errors++;
        $display("FAIL gaps_write_%0d: got addr %0h data %h, required addr %0h data %h",
                 i, wr_addr[i], wr_data[i], i, prog[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    checks += 2;
    if (cpu_rst !== 1'b1)   begin errors++; $display("FAIL zero_boot_cpu_rst: got %0b, required 1", cpu_rst); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL zero_boot_load_done: got %0b, required 0", load_done); end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    checks += 2;
    if (cpu_rst !== 1'b1)   begin errors++; $display("FAIL zero_cpu_rst_early: got %0b, required 1", cpu_rst); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL zero_load_done_early: got %0b, required 0", load_done); end
    @(posedge clk);
    #1;
    checks += 2;
    if (cpu_rst !== 1'b0)   begin errors++; $display("FAIL zero_cpu_rst: got %0b, required 0", cpu_rst); end
    if (load_done !== 1'b1) begin errors++; $display("FAIL zero_load_done: got %0b, required 1", load_done); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d, required 0", wr_addr.size()); end
  endtask

  task automatic test_overflow();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (load_err !== 1'b1)   begin errors++; $display("FAIL ovf_load_err: got %0b, required 1", load_err); end
    if (cpu_rst !== 1'b1)    begin errors++; $display("FAIL ovf_cpu_rst: got %0b, required 1", cpu_rst); end
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL ovf_in_ready: got %0b, required 0", in_ready); end
    if (load_done !== 1'b0)  begin errors++; $display("FAIL ovf_load_done: got %0b, required 0", load_done); end
    if (wr_addr.size() != 0) begin errors++; $display("FAIL ovf_writes: got %0d, required 0", wr_addr.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    pulse_boot_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 0);
    pulse_boot_start();
    checks += 3;
    if (cpu_rst !== 1'b1)   begin errors++; $display("FAIL abort_cpu_rst: got %0b, required 1", cpu_rst); end
    if (load_err !== 1'b0)  begin errors++; $display("FAIL abort_load_err: got %0b, required 0", load_err); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL abort_load_done: got %0b, required 0", load_done); end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hDEADBEEF, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(tb_csum, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (load_done !== 1'b1)  begin errors++; $display("FAIL abort_reload_done: got %0b, required 1", load_done); end
    if (wr_addr.size() != 1) begin errors++; $display("FAIL abort_write_count: got %0d, required 1", wr_addr.size()); end
    else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL abort_write: got addr %0h data %h, required addr 0 data deadbeef", wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_max_words();
    int bad = 0;
    logic [31:0] w;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) send_word({8'(i), ~8'(i), 8'(i + 1), 8'hA5}, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(tb_csum, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (load_done !== 1'b1)    begin errors++; $display("FAIL max_load_done: got %0b, required 1", load_done); end
    if (load_err !== 1'b0)     begin errors++; $display("FAIL max_load_err: got %0b, required 0", load_err); end
    if (wr_addr.size() != 256) begin errors++; $display("FAIL max_write_count: got %0d, required 256", wr_addr.size()); end
    for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
      w = {8'(i), ~8'(i), 8'(i + 1), 8'hA5};
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== w) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL max_write_contents: got %0d bad writes, required 0", bad); end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum_bad();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h12345678, 0);
    send_byte(tb_csum ^ 8'h01, 0);
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (load_err !== 1'b1)   begin errors++; $display("FAIL csum_load_err: got %0b, required 1", load_err); end
    if (cpu_rst !== 1'b1)    begin errors++; $display("FAIL csum_cpu_rst: got %0b, required 1", cpu_rst); end
    if (load_done !== 1'b0)  begin errors++; $display("FAIL csum_load_done: got %0b, required 0", load_done); end
    if (wr_addr.size() != 1) begin errors++; $display("FAIL csum_write_count: got %0d, required 1", wr_addr.size()); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    boot_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    tb_csum    = 8'h00;
    test_reset();
    test_basic_load();
    pulse_boot_start();
    test_gaps();
    pulse_boot_start();
    test_zero_len();
    pulse_boot_start();
    test_overflow();
    test_abort();
    pulse_boot_start();
    test_max_words();
`ifdef BOOT_CHECKSUM_EN
    pulse_boot_start();
    test_checksum_bad();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
